div4_seq: RTL and testbench
===========================

Name: div4_seq

Overview:
- Sequential unsigned restoring divider: the inverse operation of the team's combinational shift-add multiplier.
- Produces quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic-logic library.
- Uses a start/done handshake so ALU control logic can issue a divide and wait for it.

Parameters:
- WIDTH, 4, operand/result width in bits (must be ≥2).

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- start  input  1  request; sampled only when ready=1
- a  input  WIDTH  dividend, captured on accepted start
- b  input  WIDTH  divisor, captured on accepted start
- ready  output  1  block can accept start this cycle
- busy  output  1  division in progress
- done  output  1  one-cycle pulse; q/r/dbz valid this cycle
- q  output  WIDTH  quotient
- r  output  WIDTH  remainder
- dbz  output  1  divide-by-zero flag for the current result

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; q=0, r=0, dbz=0, done=0, busy=0, ready=1; internal counter=0.
  - Reset mid-operation aborts the division with no done pulse.
- States: IDLE, RUN, DONE.
- ready=1 in IDLE and DONE. busy=1 in RUN only. done=1 in DONE only.
- Accept: at an edge with ready=1 and start=1, capture a and b.
  - If b==0: go to DONE. Set q=all ones, r=a, dbz=1. done is asserted in the next cycle (latency 1).
  - Otherwise: go to RUN with dividend shift reg=a, partial remainder P=0, count=WIDTH, dbz=0.
- RUN step, per cycle:
  - P' = {P[WIDTH-2:0], msb of dividend shift reg}; shift the dividend left by one.
  - If P' ≥ b: P = P' − b, shift in quotient bit 1. Else: P = P', shift in quotient bit 0.
  - Decrement count. After the step that brings count to 0, go to DONE.
  - Latency: done asserted WIDTH+1 cycles after the accepting edge (5 for WIDTH=4).
- Arithmetic width:
  - The subtract/compare uses WIDTH+1 bits internally so P' cannot overflow.
  - The final remainder is always < b and fits in WIDTH bits.
- DONE: q and r present the final values; dbz is valid. Next state is IDLE, unless start=1, which performs a back-to-back accept as above.
- Output hold: q, r, dbz hold their last values through IDLE until the next accepted start. During RUN, q and r are don't-care internally but must not glitch into done.
- start while busy=1: ignored, with no queuing.
- a and b are not sampled outside the accepting edge; changing them during RUN has no effect.
- Simultaneous rst_n=0 and start=1: reset wins.

Decomposition:
- Shared package (arith_pkg):
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - count width constant CNT_W=$clog2(WIDTH+1).
- One natural sub-module, div_step: combinational.
  - Inputs: P, next dividend bit, b.
  - Outputs: new P and quotient bit.
  - Instantiated once and reused per cycle.
- Everything else (FSM, registers) stays in div4_seq.

Test Plan:
- Reset then a=13, b=3, start for 1 cycle -> busy for 4 cycles; done pulses exactly 5 cycles after the accepting edge with q=4, r=1, dbz=0; done low the following cycle.
- a=15, b=1 -> q=15, r=0. a=7, b=9 -> q=0, r=7. a=0, b=5 -> q=0, r=0. All with latency 5.
- a=9, b=0 -> done 1 cycle after accept, q=4'hF, r=9, dbz=1. Next divide 8/2 clears dbz: q=4, r=0.
- Start 6/4; change a/b and pulse start during RUN -> changes ignored, single done with q=1, r=2; no second done.
- Start held high across DONE with a=14, b=5 -> second divide accepted in the DONE cycle; next done 5 cycles later with q=2, r=4.
- rst_n low for one edge in the middle of RUN -> no done pulse, outputs back to 0, ready=1. A subsequent 10/3 yields q=3, r=1.
- Exhaustive sweep over all 256 (a,b) pairs, with a self-checking model of a/b and a%b and the dbz rule -> zero mismatches.

Source files
------------

// File: rtl/div4_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the width of the step counter.
package div4_seq_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // The counter has to hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/div4_seq_if.sv
// Start/done handshake and operand/result bus for the divider.
interface div4_seq_if
  import div4_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             dbz;

  // ALU control side: issues divides, waits for done.
  modport master (
    output start, a, b,
    input  ready, busy, done, q, r, dbz
  );

  // Divider side.
  modport slave (
    input  start, a, b,
    output ready, busy, done, q, r, dbz
  );

endinterface

// File: rtl/div4_seq_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] p_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] p_o,
  output logic             q_o
);

  // One extra bit so the shifted remainder cannot overflow before the compare.
  logic [WIDTH:0] p_sh;

  assign p_sh = {p_i, bit_i};
  assign q_o  = (p_sh >= {1'b0, b_i});
  // When the subtract is taken the result is < b, so the low WIDTH bits are exact.
  assign p_o  = q_o ? (p_sh[WIDTH-1:0] - b_i) : p_sh[WIDTH-1:0];

endmodule

// File: rtl/div4_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for start; q/r/dbz hold the previous result
//   S_RUN  | shifting out one quotient bit per cycle, cnt_q steps left
//   S_DONE | done pulse; q/r/dbz valid; a new start is accepted here too
module div4_seq
  import div4_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic     clk,
  input  logic     rst_n,
  div4_seq_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q;
  // Dividend shifts out at the top while quotient bits shift in at the bottom,
  // so after WIDTH steps this register holds the quotient.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic             dbz_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] p_d;
  logic             qbit_d;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_i   (p_q),
    .bit_i (dvd_q[WIDTH-1]),
    .b_i   (b_q),
    .p_o   (p_d),
    .q_o   (qbit_d)
  );

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      p_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            if (bus.b == '0) begin
              // Divide by zero resolves immediately with the saturated quotient.
              state_q <= S_DONE;
              q_q     <= '1;
              r_q     <= bus.a;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_RUN;
              dvd_q   <= bus.a;
              b_q     <= bus.b;
              p_q     <= '0;
              cnt_q   <= CW'(WIDTH);
              dbz_q   <= 1'b0;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          dvd_q <= {dvd_q[WIDTH-2:0], qbit_d};
          p_q   <= p_d;
          cnt_q <= cnt_q - CW'(1);
          // Results are only published on the final step so q/r never show
          // intermediate values.
          if (cnt_q == CW'(1)) begin
            state_q <= S_DONE;
            q_q     <= {dvd_q[WIDTH-2:0], qbit_d};
            r_q     <= p_d;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.q     = q_q;
  assign bus.r     = r_q;
  assign bus.dbz   = dbz_q;

endmodule

// File: tb/tb_div4_seq.sv
// Bench for div4_seq: directed scenarios, random operands and an exhaustive
// sweep, all checked against a plain a/b, a%b reference.
module tb_div4_seq;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  div4_seq_if #(.WIDTH(W)) dif ();

  div4_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model
  function automatic logic [W-1:0] ref_q(input int a, input int b);
    if (b == 0) return {W{1'b1}};
    return W'(a / b);
  endfunction

  function automatic logic [W-1:0] ref_r(input int a, input int b);
    if (b == 0) return W'(a);
    return W'(a % b);
  endfunction

  function automatic int ref_lat(input int b);
    return (b == 0) ? 1 : W + 1;
  endfunction

  // Issue one divide and report latency (cycles from accepting edge), busy
  // cycles and the results seen in the done cycle. lat=-1 if done never came.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cnt,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dbz);
    @(negedge clk);
    dif.start = 1'b1;
    dif.a = a;
    dif.b = b;
    @(posedge clk);
    lat = -1;
    busy_cnt = 0;
    q = 'x;
    r = 'x;
    dbz = 1'bx;
    for (int k = 1; k <= 3 * W + 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        dif.start = 1'b0;
        dif.a = W'($urandom);
        dif.b = W'($urandom);
      end
      if (dif.busy) busy_cnt++;
      if (dif.done) begin
        lat = k;
        q = dif.q;
        r = dif.r;
        dbz = dif.dbz;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dif.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({dif.ready, dif.busy, dif.done, dif.dbz} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_flags: got rdy/busy/done/dbz=%b expected 1000",
               {dif.ready, dif.busy, dif.done, dif.dbz});
    end
    vectors++;
    if (dif.q !== 0 || dif.r !== 0) begin
      miscompares++;
      $display("FAIL reset_qr: got q=%0d r=%0d expected 0 0", dif.q, dif.r);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (dif.ready !== 1'b1 || dif.done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got ready=%b done=%b expected 1 0",
               dif.ready, dif.done);
    end
  endtask

  task automatic test_basic();
    int pa[4] = '{13, 15, 7, 0};
    int pb[4] = '{3, 1, 9, 5};
    int lat, bc;
    logic [W-1:0] q, r;
    logic dbz;
    for (int i = 0; i < 4; i++) begin
      run_div(W'(pa[i]), W'(pb[i]), lat, bc, q, r, dbz);
      vectors++;
      if (lat !== W + 1) begin
        miscompares++;
        $display("FAIL basic_lat %0d/%0d: got %0d expected %0d", pa[i], pb[i], lat, W + 1);
      end
      vectors++;
      if (bc !== W) begin
        miscompares++;
        $display("FAIL basic_busy %0d/%0d: got %0d cycles expected %0d", pa[i], pb[i], bc, W);
      end
      vectors++;
      if (q !== ref_q(pa[i], pb[i]) || r !== ref_r(pa[i], pb[i]) || dbz !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_result %0d/%0d: got q=%0d r=%0d dbz=%b expected q=%0d r=%0d dbz=0",
                 pa[i], pb[i], q, r, dbz, ref_q(pa[i], pb[i]), ref_r(pa[i], pb[i]));
      end
      @(negedge clk);
      vectors++;
      if (dif.done !== 1'b0) begin
        miscompares++;
        $display("FAIL done_pulse_width %0d/%0d: got done=%b expected 0", pa[i], pb[i], dif.done);
      end
      vectors++;
      if (dif.q !== ref_q(pa[i], pb[i]) || dif.r !== ref_r(pa[i], pb[i])) begin
        miscompares++;
        $display("FAIL hold_in_idle %0d/%0d: got q=%0d r=%0d expected q=%0d r=%0d",
                 pa[i], pb[i], dif.q, dif.r, ref_q(pa[i], pb[i]), ref_r(pa[i], pb[i]));
      end
    end
  endtask

  task automatic test_dbz();
    int lat, bc;
    logic [W-1:0] q, r;
    logic dbz;
    run_div(4'd9, 4'd0, lat, bc, q, r, dbz);
    vectors++;
    if (lat !== 1) begin
      miscompares++;
      $display("FAIL dbz_lat: got %0d expected 1", lat);
    end
    vectors++;
    if (q !== 4'hF || r !== 4'd9 || dbz !== 1'b1) begin
      miscompares++;
      $display("FAIL dbz_result: got q=%0d r=%0d dbz=%b expected q=15 r=9 dbz=1", q, r, dbz);
    end
    run_div(4'd8, 4'd2, lat, bc, q, r, dbz);
    vectors++;
    if (q !== 4'd4 || r !== 4'd0 || dbz !== 1'b0 || lat !== W + 1) begin
      miscompares++;
      $display("FAIL dbz_clear: got q=%0d r=%0d dbz=%b lat=%0d expected q=4 r=0 dbz=0 lat=%0d",
               q, r, dbz, lat, W + 1);
    end
  endtask

  task automatic test_ignore_run();
    int done_cnt = 0;
    int lat = -1;
    logic [W-1:0] q = 'x, r = 'x;
    @(negedge clk);
    dif.start = 1'b1;
    dif.a = 4'd6;
    dif.b = 4'd4;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        dif.a = 4'd15;
        dif.b = 4'd1;
      end
      if (k == 3) dif.start = 1'b0;
      if (dif.done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = k;
          q = dif.q;
          r = dif.r;
        end
      end
    end
    vectors++;
    if (lat !== W + 1 || q !== 4'd1 || r !== 4'd2) begin
      miscompares++;
      $display("FAIL ignore_run_result: got lat=%0d q=%0d r=%0d expected lat=%0d q=1 r=2",
               lat, q, r, W + 1);
    end
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++;
      $display("FAIL ignore_run_single_done: got %0d done pulses expected 1", done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int lat1 = -1, lat2 = -1;
    logic [W-1:0] q1 = 'x, r1 = 'x, q2 = 'x, r2 = 'x;
    @(negedge clk);
    dif.start = 1'b1;
    dif.a = 4'd13;
    dif.b = 4'd3;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        dif.a = 4'd14;
        dif.b = 4'd5;
      end
      if (dif.done) begin
        lat1 = k;
        q1 = dif.q;
        r1 = dif.r;
        break;
      end
    end
    // start is still high here, so this edge is the second accept.
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) dif.start = 1'b0;
      if (dif.done) begin
        lat2 = k;
        q2 = dif.q;
        r2 = dif.r;
        break;
      end
    end
    vectors++;
    if (lat1 !== W + 1 || q1 !== 4'd4 || r1 !== 4'd1) begin
      miscompares++;
      $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d expected lat=%0d q=4 r=1", lat1, q1, r1, W + 1);
    end
    vectors++;
    if (lat2 !== W + 1 || q2 !== 4'd2 || r2 !== 4'd4) begin
      miscompares++;
      $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d expected lat=%0d q=2 r=4", lat2, q2, r2, W + 1);
    end
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0;
    int lat, bc;
    logic [W-1:0] q, r;
    logic dbz;
    @(negedge clk);
    dif.start = 1'b1;
    dif.a = 4'd13;
    dif.b = 4'd3;
    @(posedge clk);
    @(negedge clk);
    dif.start = 1'b0;
    @(negedge clk);
    // Reset and a divide-by-zero request on the same edge: reset must win.
    rst_n = 1'b0;
    dif.start = 1'b1;
    dif.a = 4'd5;
    dif.b = 4'd0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dif.start = 1'b0;
    vectors++;
    if ({dif.ready, dif.busy, dif.done, dif.dbz} !== 4'b1000 || dif.q !== 0 || dif.r !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_state: got rdy/busy/done/dbz=%b q=%0d r=%0d expected 1000 q=0 r=0",
               {dif.ready, dif.busy, dif.done, dif.dbz}, dif.q, dif.r);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dif.done) done_cnt++;
    end
    vectors++;
    if (done_cnt !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", done_cnt);
    end
    run_div(4'd10, 4'd3, lat, bc, q, r, dbz);
    vectors++;
    if (q !== 4'd3 || r !== 4'd1 || dbz !== 1'b0 || lat !== W + 1) begin
      miscompares++;
      $display("FAIL reset_mid_after: got q=%0d r=%0d dbz=%b lat=%0d expected q=3 r=1 dbz=0 lat=%0d",
               q, r, dbz, lat, W + 1);
    end
  endtask

  task automatic test_random();
    int lat, bc, ia, ib;
    logic [W-1:0] q, r;
    logic dbz;
    for (int n = 0; n < 40; n++) begin
      ia = int'($urandom_range(0, (1 << W) - 1));
      ib = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, (1 << W) - 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_div(W'(ia), W'(ib), lat, bc, q, r, dbz);
      vectors++;
      if (q !== ref_q(ia, ib) || r !== ref_r(ia, ib) || dbz !== (ib == 0) || lat !== ref_lat(ib)) begin
        miscompares++;
        $display("FAIL random %0d/%0d: got q=%0d r=%0d dbz=%b lat=%0d expected q=%0d r=%0d dbz=%b lat=%0d",
                 ia, ib, q, r, dbz, lat, ref_q(ia, ib), ref_r(ia, ib), ib == 0, ref_lat(ib));
      end
    end
  endtask

  task automatic test_sweep();
    int lat, bc;
    logic [W-1:0] q, r;
    logic dbz;
    for (int ia = 0; ia < (1 << W); ia++) begin
      for (int ib = 0; ib < (1 << W); ib++) begin
        run_div(W'(ia), W'(ib), lat, bc, q, r, dbz);
        vectors++;
        if (q !== ref_q(ia, ib) || r !== ref_r(ia, ib) || dbz !== (ib == 0) || lat !== ref_lat(ib)) begin
          miscompares++;
          $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dbz=%b lat=%0d expected q=%0d r=%0d dbz=%b lat=%0d",
                   ia, ib, q, r, dbz, lat, ref_q(ia, ib), ref_r(ia, ib), ib == 0, ref_lat(ib));
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.start = 1'b0;
    dif.a = '0;
    dif.b = '0;
    test_reset();
    test_basic();
    test_dbz();
    test_ignore_run();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
